// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART transmit scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } uart_sched_state_t;

    localparam int unsigned SCHED_NREQ_DEF = 2;
    localparam int unsigned SCHED_CNT_W    = 4;

    // Grant index width; never below one bit so single-bit ports stay legal.
    function automatic int unsigned sched_id_w(input int unsigned nreq);
        return (nreq > 32'd1) ? 32'($clog2(nreq)) : 32'd1;
    endfunction

    localparam int unsigned SCHED_ID_W = sched_id_w(SCHED_NREQ_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first asserted req strictly after last_grant, with wrap.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned NREQ = SCHED_NREQ_DEF,
    localparam int unsigned ID_W = sched_id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last_grant,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid
);

    // Two passes: indices above the pointer first, then the wrapped-around ones.
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_valid = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!gnt_valid && req[i] && (i > 32'(last_grant))) begin
                gnt_valid = 1'b1;
                gnt[i]    = 1'b1;
                gnt_id    = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!gnt_valid && req[i] && (i <= 32'(last_grant))) begin
                gnt_valid = 1'b1;
                gnt[i]    = 1'b1;
                gnt_id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler in front of a single UART transmitter core.
// Optional message lock (requester keeps the line until req_last) under UART_SCHED_LOCK_EN.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int unsigned NREQ        = SCHED_NREQ_DEF,
    parameter  int unsigned ACK_TIMEOUT = 4,
    localparam int unsigned ID_W        = sched_id_w(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*8-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          core_data,
    output logic                core_wr,
    input  logic                core_busy,
    output logic [ID_W-1:0]     grant_id,
    output logic                active,
    output logic                err_timeout,
    input  logic                err_clr
);

    localparam int unsigned CNT_W = SCHED_CNT_W;

    uart_sched_state_t state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [NREQ-1:0]   req_elig;
    logic [NREQ-1:0]   arb_gnt;
    logic [ID_W-1:0]   arb_id;
    logic              arb_valid;
    logic [7:0]        sel_data;
    logic              accept;
    logic              timeout;

`ifdef UART_SCHED_LOCK_EN
    logic              lock_q;
    logic [ID_W-1:0]   lock_id;
    logic [NREQ-1:0]   lock_mask;

    // While locked, only the owner of the open message may be picked.
    always_comb begin
        lock_mask = NREQ'(1) << lock_id;
        req_elig  = lock_q ? (req_valid & lock_mask) : req_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q  <= 1'b0;
            lock_id <= '0;
        end else if (timeout) begin
            lock_q  <= 1'b0;
        end else if (accept) begin
            lock_q  <= ~(|(req_last & arb_gnt));
            lock_id <= arb_id;
        end
    end
`else
    logic unused_req_last;

    always_comb begin
        req_elig = req_valid;
    end

    assign unused_req_last = ^req_last;
`endif

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req        (req_elig),
        .last_grant (last_grant),
        .gnt        (arb_gnt),
        .gnt_id     (arb_id),
        .gnt_valid  (arb_valid)
    );

    // Byte of the current winner.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    // Next state, timeout counter, and combinational ready.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        timeout   = 1'b0;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (!reset && !core_busy && arb_valid) begin
                    accept    = 1'b1;
                    req_ready = arb_gnt;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (core_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_W'(ACK_TIMEOUT - 2)) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!core_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= ID_W'(NREQ - 1);
            core_data  <= '0;
            core_wr    <= 1'b0;
            grant_id   <= '0;
            active     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            core_wr <= (state_nxt == LOAD);
            active  <= (state_nxt != IDLE);
            if (accept) begin
                core_data  <= sel_data;
                last_grant <= arb_id;
                grant_id   <= arb_id;
            end
        end
    end

    // Sticky error; a same-cycle timeout beats the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_timeout <= 1'b0;
        end else if (timeout) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (NREQ=2, ACK_TIMEOUT=4); lock expectations follow UART_SCHED_LOCK_EN.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int unsigned NREQ        = 2;
    localparam int unsigned ACK_TIMEOUT = 4;
    localparam int unsigned ID_W        = SCHED_ID_W;
    localparam int          QD          = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*8-1:0]   req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic [7:0]          core_data;
    logic                core_wr;
    logic                core_busy;
    logic [ID_W-1:0]     grant_id;
    logic                active;
    logic                err_timeout;
    logic                err_clr;

    uart_tx_sched #(
        .NREQ        (NREQ),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .core_data   (core_data),
        .core_wr     (core_wr),
        .core_busy   (core_busy),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    // UART core model: logs every strobed byte, then stays busy for busy_len cycles.
    int         busy_cnt   = 0;
    int         busy_len   = 10;
    bit         rand_busy  = 1'b0;
    bit         core_mute  = 1'b0;
    bit         force_busy = 1'b0;
    logic [7:0] core_log[$];

    always @(negedge clk) begin
        if (core_wr) begin
            core_log.push_back(core_data);
            if (!core_mute) busy_cnt = rand_busy ? int'($urandom_range(2, 7)) : busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
    end

    assign core_busy = force_busy || (busy_cnt != 0);

    // Requester byte queues and the reference arbitration model.
    logic [7:0] qd [NREQ][QD];
    bit         ql [NREQ][QD];
    int         qh [NREQ];
    int         qt [NREQ];
    int         exp_last;
    bit         exp_lock;
    int         exp_lock_id;
    int         exp_id[$];
    logic [7:0] exp_byte[$];
    int         acc_log[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic clear_queues();
        for (int i = 0; i < NREQ; i++) begin
            qh[i] = 0;
            qt[i] = 0;
        end
        exp_id.delete();
        exp_byte.delete();
        acc_log.delete();
        core_log.delete();
    endtask

    task automatic push_req(input int r, input logic [7:0] d, input bit last);
        qd[r][qt[r]] = d;
        ql[r][qt[r]] = last;
        qt[r] = qt[r] + 1;
    endtask

    // Expected grant order: next non-empty requester after the previous winner, honouring an open message lock.
    task automatic build_expected();
        int h[NREQ];
        int remaining;
        int w;
        int c;
        remaining = 0;
        for (int i = 0; i < NREQ; i++) begin
            h[i] = qh[i];
            remaining += qt[i] - qh[i];
        end
        while (remaining > 0) begin
            w = -1;
`ifdef UART_SCHED_LOCK_EN
            if (exp_lock) begin
                if (h[exp_lock_id] >= qt[exp_lock_id]) break;
                w = exp_lock_id;
            end
`endif
            for (int k = 1; k <= NREQ && w < 0; k++) begin
                c = (exp_last + k) % NREQ;
                if (h[c] < qt[c]) w = c;
            end
            exp_id.push_back(w);
            exp_byte.push_back(qd[w][h[w]]);
`ifdef UART_SCHED_LOCK_EN
            exp_lock    = !ql[w][h[w]];
            exp_lock_id = w;
`endif
            h[w] = h[w] + 1;
            exp_last = w;
            remaining = remaining - 1;
        end
    endtask

    // Presents queue heads as valid until drained; reports completion and any ready-protocol violation.
    task automatic run_stream(input int budget, output bit ok, output bit viol);
        logic [NREQ-1:0] acc_prev;
        logic [NREQ-1:0] acc;
        bit              empty;
        int              n;
        acc_prev = '0;
        ok       = 1'b0;
        viol     = 1'b0;
        n        = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (acc_prev[i]) begin
                    qh[i] = qh[i] + 1;
                    acc_log.push_back(i);
                end
            end
            empty = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = (qh[i] < qt[i]);
                req_data[8*i +: 8] = req_valid[i] ? qd[i][qh[i]] : 8'($urandom);
                req_last[i] = req_valid[i] ? ql[i][qh[i]] : 1'($urandom);
                if (req_valid[i]) empty = 1'b0;
            end
            #1;
            acc = req_valid & req_ready;
            if (((req_ready & ~req_valid) != '0) || ($countones(req_ready) > 1)) viol = 1'b1;
            acc_prev = acc;
            ok = (acc == '0) && empty && !active && !core_busy;
            n++;
        end
        req_valid = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        err_clr   = 1'b0;
        @(negedge clk);
        reset       = 1'b0;
        exp_last    = NREQ - 1;
        exp_lock    = 1'b0;
        exp_lock_id = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        req_valid = 2'b11;
        req_data  = 16'($urandom);
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", req_ready); end
        n_cmp++; if (core_wr !== 1'b0) begin n_fail++; $display("FAIL reset_core_wr got %b want 0", core_wr); end
        n_cmp++; if (core_data !== 8'h00) begin n_fail++; $display("FAIL reset_core_data got %h want 00", core_data); end
        n_cmp++; if (grant_id !== '0) begin n_fail++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", active); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_timeout); end
        @(negedge clk);
        req_valid   = '0;
        reset       = 1'b0;
        exp_last    = NREQ - 1;
        exp_lock    = 1'b0;
        exp_lock_id = 0;
    endtask

    task automatic test_single();
        int         c_acc, c_wr, c_bfall, c_afall, n_acc, n_wr;
        logic [1:0] rdy_val;
        logic [7:0] wr_data;
        bit         seen_busy;
        apply_reset();
        busy_len = 10;
        c_acc = -1; c_wr = -1; c_bfall = -1; c_afall = -1;
        n_acc = 0; n_wr = 0; seen_busy = 0; rdy_val = '0; wr_data = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            req_valid = (c_acc < 0) ? 2'b01 : 2'b00;
            req_data  = 16'h0041;
            req_last  = 2'b11;
            #1;
            if (req_ready != 2'b00) begin
                n_acc++;
                if (c_acc < 0) begin c_acc = c; rdy_val = req_ready; end
            end
            if (core_wr) begin n_wr++; c_wr = c; wr_data = core_data; end
            if (core_busy) seen_busy = 1;
            else if (seen_busy && c_bfall < 0) c_bfall = c;
            if (c_wr >= 0 && c > c_wr && !active && c_afall < 0) c_afall = c;
        end
        n_cmp++; if (n_acc != 1) begin n_fail++; $display("FAIL single_ready_pulses got %0d want 1", n_acc); end
        n_cmp++; if (rdy_val !== 2'b01) begin n_fail++; $display("FAIL single_ready_value got %b want 01", rdy_val); end
        n_cmp++; if (n_wr != 1) begin n_fail++; $display("FAIL single_wr_pulses got %0d want 1", n_wr); end
        n_cmp++; if (c_wr != c_acc + 1) begin n_fail++; $display("FAIL single_wr_latency got %0d want %0d", c_wr, c_acc + 1); end
        n_cmp++; if (wr_data !== 8'h41) begin n_fail++; $display("FAIL single_core_data got %h want 41", wr_data); end
        n_cmp++; if (c_bfall < 0 || c_afall != c_bfall + 1) begin n_fail++; $display("FAIL single_active_fall got %0d want %0d", c_afall, c_bfall + 1); end
        n_cmp++; if (grant_id !== '0) begin n_fail++; $display("FAIL single_grant_id got %0d want 0", grant_id); end
    endtask

    task automatic test_round_robin();
        logic [7:0] want[4];
        bit ok, viol;
        apply_reset();
        clear_queues();
        busy_len = 5;
        push_req(0, 8'h10, 1); push_req(0, 8'h11, 1);
        push_req(1, 8'h20, 1); push_req(1, 8'h21, 1);
        want[0] = 8'h10; want[1] = 8'h20; want[2] = 8'h11; want[3] = 8'h21;
        build_expected();
        run_stream(300, ok, viol);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rr_drain got incomplete want drained in 300 cycles"); end
        n_cmp++; if (viol) begin n_fail++; $display("FAIL rr_ready_protocol got violation want none"); end
        n_cmp++; if (core_log.size() != 4) begin n_fail++; $display("FAIL rr_count got %0d want 4", core_log.size()); end
        for (int k = 0; k < 4 && k < core_log.size(); k++) begin
            n_cmp++; if (core_log[k] !== want[k]) begin n_fail++; $display("FAIL rr_byte%0d got %h want %h", k, core_log[k], want[k]); end
        end
    endtask

    task automatic test_core_busy();
        bit done;
        apply_reset();
        clear_queues();
        busy_len   = 6;
        force_busy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = 2'b01;
            req_data  = 16'h0055;
            #1;
            n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL busy_hold_ready%0d got %b want 00", c, req_ready); end
        end
        @(negedge clk);
        force_busy = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL busy_release_ready got %b want 01", req_ready); end
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            done = !active && !core_busy;
        end
        n_cmp++; if (!done) begin n_fail++; $display("FAIL busy_drain got incomplete want idle"); end
        n_cmp++; if (core_log.size() != 1 || core_log[0] !== 8'h55) begin n_fail++; $display("FAIL busy_byte got size %0d want one byte 55", core_log.size()); end
    endtask

    task automatic test_timeout();
        apply_reset();
        clear_queues();
        core_mute = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            req_valid = 2'b01;
            req_data  = 16'h0077;
            req_last  = 2'b11;
            #1;
            n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL to%0d_ready got %b want 01", b, req_ready); end
            @(negedge clk);
            req_valid = '0;
            #1;
            n_cmp++; if (core_wr !== 1'b1) begin n_fail++; $display("FAIL to%0d_wr got %b want 1", b, core_wr); end
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                err_clr = (b == 1 && k == 3);
                #1;
                n_cmp++; if (err_timeout !== (k == 4)) begin n_fail++; $display("FAIL to%0d_err_c%0d got %b want %b", b, k, err_timeout, k == 4); end
            end
            err_clr = 1'b0;
            n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL to%0d_idle got active %b want 0", b, active); end
            @(negedge clk);
            #1;
            n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to%0d_sticky got %b want 1", b, err_timeout); end
            @(negedge clk);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            #1;
            n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL to%0d_clear got %b want 0", b, err_timeout); end
        end
        core_mute = 1'b0;
    endtask

    task automatic test_lock();
        int want_id[5];
        bit ok, viol;
        apply_reset();
        clear_queues();
        busy_len = 4;
        push_req(0, 8'hA0, 0); push_req(0, 8'hA1, 0); push_req(0, 8'hA2, 1);
        push_req(1, 8'hB0, 1); push_req(1, 8'hB1, 1);
`ifdef UART_SCHED_LOCK_EN
        want_id[0] = 0; want_id[1] = 0; want_id[2] = 0; want_id[3] = 1; want_id[4] = 1;
`else
        want_id[0] = 0; want_id[1] = 1; want_id[2] = 0; want_id[3] = 1; want_id[4] = 0;
`endif
        build_expected();
        run_stream(300, ok, viol);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL lock_drain got incomplete want drained"); end
        n_cmp++; if (acc_log.size() != 5 || core_log.size() != 5) begin n_fail++; $display("FAIL lock_count got %0d/%0d want 5/5", acc_log.size(), core_log.size()); end
        for (int k = 0; k < 5 && k < acc_log.size() && k < core_log.size(); k++) begin
            n_cmp++; if (acc_log[k] != want_id[k]) begin n_fail++; $display("FAIL lock_id%0d got %0d want %0d", k, acc_log[k], want_id[k]); end
            n_cmp++; if (core_log[k] !== exp_byte[k]) begin n_fail++; $display("FAIL lock_byte%0d got %h want %h", k, core_log[k], exp_byte[k]); end
        end
    endtask

    task automatic test_random();
        int len;
        bit ok, viol;
        apply_reset();
        rand_busy = 1'b1;
        for (int it = 0; it < 8; it++) begin
            clear_queues();
            for (int r = 0; r < NREQ; r++) begin
                len = $urandom_range(1, 5);
                for (int j = 0; j < len; j++) push_req(r, 8'($urandom), (j == len - 1) ? 1'b1 : 1'($urandom));
            end
            build_expected();
            run_stream(600, ok, viol);
            n_cmp++; if (!ok || viol) begin n_fail++; $display("FAIL rand%0d_run got ok=%0d viol=%0d want ok=1 viol=0", it, ok, viol); end
            n_cmp++; if (acc_log.size() != exp_id.size() || core_log.size() != exp_byte.size()) begin
                n_fail++; $display("FAIL rand%0d_count got %0d/%0d want %0d", it, acc_log.size(), core_log.size(), exp_id.size());
            end
            for (int k = 0; k < exp_id.size() && k < acc_log.size() && k < core_log.size(); k++) begin
                n_cmp++; if (acc_log[k] != exp_id[k] || core_log[k] !== exp_byte[k]) begin
                    n_fail++; $display("FAIL rand%0d_item%0d got id %0d byte %h want id %0d byte %h", it, k, acc_log[k], core_log[k], exp_id[k], exp_byte[k]);
                end
            end
        end
        rand_busy = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [1:0] first;
        bit         found;
        apply_reset();
        clear_queues();
        busy_len = 20;
        @(negedge clk);
        req_valid = 2'b10;
        req_data  = 16'h9900;
        req_last  = 2'b11;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rmid_accept got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (active !== 1'b1 || grant_id !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got active %b grant %0d want 1 1", active, grant_id); end
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 2'b11;
        req_data  = 16'h2211;
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rmid_ready_in_reset got %b want 00", req_ready); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (core_wr !== 1'b0 || active !== 1'b0 || grant_id !== '0) begin
            n_fail++; $display("FAIL rmid_post got wr %b active %b grant %0d want 0 0 0", core_wr, active, grant_id);
        end
        n_cmp++; if (core_busy !== 1'b1 || req_ready !== 2'b00) begin n_fail++; $display("FAIL rmid_wait_busy got busy %b ready %b want 1 00", core_busy, req_ready); end
        found = 0;
        first = '0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            #1;
            if (req_ready != 2'b00) begin
                found = 1;
                first = req_ready;
                n_cmp++; if (core_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_accept_while_busy got busy %b want 0", core_busy); end
            end
        end
        n_cmp++; if (!found || first !== 2'b01) begin n_fail++; $display("FAIL rmid_next_winner got %b want 01", first); end
        @(negedge clk);
        req_valid = '0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        err_clr   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_core_busy();
        test_timeout();
        test_lock();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no completion want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
